// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, access kinds and word size.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } mem_op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, resettable read port.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the lw/sw interface: stalls the CPU for a fixed latency,
// then performs the word access and pulses done (or err for a rejected request).
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFS_W = $clog2(WORD_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t       state, next_state;
    logic [CNT_W-1:0]  cnt;
    mem_op_t           op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rejected_q;
    logic              legal_req, illegal_req, access;
    logic              unused_addr;

    assign unused_addr = ^addr[ADDR_W-1:IDX_W+OFS_W];

    // Any op pattern other than exactly one of read/write (including X) is rejected.
    always_comb begin
        legal_req   = 1'b0;
        illegal_req = 1'b0;
        case ({mem_read, mem_write})
            2'b00: ;
            2'b01, 2'b10: begin
                if (addr[OFS_W-1:0] == '0) begin
                    legal_req = 1'b1;
                end else begin
                    illegal_req = 1'b1;
                end
            end
            default: illegal_req = 1'b1;
        endcase
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (legal_req) begin
                    next_state = BUSY;
                    stall      = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    access     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rejected_q remembers that the held request was already flagged, so err fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            err        <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state      <= next_state;
            err        <= (state == IDLE) && illegal_req && !rejected_q;
            rejected_q <= (state == IDLE) && illegal_req;
            if (state == IDLE && legal_req) begin
                cnt <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && legal_req) begin
            op_q    <= mem_write ? OP_STORE : OP_LOAD;
            idx_q   <= addr[OFS_W +: IDX_W];
            wdata_q <= wdata;
        end
    end

    assign done = (state == DONE);

    // Gating with rst keeps a store that is cut off by reset out of the RAM.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (access && (op_q == OP_STORE) && !rst),
        .re    (access && (op_q == OP_LOAD) && !rst),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder at LATENCY=2 and LATENCY=1,
// compared against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_s  [2];
    logic        mem_write_s [2];
    logic [31:0] addr_s      [2];
    logic [31:0] wdata_s     [2];
    logic [31:0] rdata_s     [2];
    logic        stall_s     [2];
    logic        done_s      [2];
    logic        err_s       [2];

    logic [31:0] ram_model   [2][256];
    logic [31:0] rdata_model [2];

    int total_checks  = 0;
    int passed_checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]),
        .rdata(rdata_s[0]), .stall(stall_s[0]), .done(done_s[0]), .err(err_s[0])
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]),
        .rdata(rdata_s[1]), .stall(stall_s[1]), .done(done_s[1]), .err(err_s[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic checkIdleOutputs(input int u, input string tag);
        checkOutput($sformatf("u%0d %s stall", u, tag), 32'(stall_s[u]), 32'd0);
        checkOutput($sformatf("u%0d %s done", u, tag), 32'(done_s[u]), 32'd0);
        checkOutput($sformatf("u%0d %s rdata", u, tag), rdata_s[u], rdata_model[u]);
    endtask

    // One CPU instruction: request held until the model says it retires (or is rejected).
    task automatic applyStimulus(input int u, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd);
        int   lat;
        int   idx;
        logic legal;
        lat   = (u == 0) ? 2 : 1;
        idx   = int'(a[9:2]);
        legal = (rd != wr) && (a[1:0] == 2'b00);
        @(posedge clk); #1;
        mem_read_s[u]  = rd;
        mem_write_s[u] = wr;
        addr_s[u]      = a;
        wdata_s[u]     = wd;
        if (legal) begin
            for (int c = 0; c <= lat + 1; c++) begin
                @(negedge clk);
                if (c == lat + 1) begin
                    if (wr) ram_model[u][idx] = wd;
                    else    rdata_model[u] = ram_model[u][idx];
                end
                checkOutput($sformatf("u%0d a=%h stall c%0d", u, a, c), 32'(stall_s[u]), 32'(c <= lat));
                checkOutput($sformatf("u%0d a=%h done c%0d", u, a, c), 32'(done_s[u]), 32'(c == lat + 1));
                checkOutput($sformatf("u%0d a=%h err c%0d", u, a, c), 32'(err_s[u]), 32'd0);
                checkOutput($sformatf("u%0d a=%h rdata c%0d", u, a, c), rdata_s[u], rdata_model[u]);
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checkIdleOutputs(u, $sformatf("rej a=%h c%0d", a, c));
                checkOutput($sformatf("u%0d rej a=%h err c%0d", u, a, c), 32'(err_s[u]), 32'(c == 1));
            end
        end
        @(posedge clk); #1;
        mem_read_s[u]  = 1'b0;
        mem_write_s[u] = 1'b0;
    endtask

    task automatic holdCheck(input int u, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkIdleOutputs(u, $sformatf("hold c%0d", c));
        end
    endtask

    // Store on LATENCY=2 unit, with reset arriving in its second BUSY cycle.
    task automatic resetMidStore(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        mem_write_s[0] = 1'b1;
        addr_s[0]      = a;
        wdata_s[0]     = wd;
        @(negedge clk);
        checkOutput("rstmid stall c0", 32'(stall_s[0]), 32'd1);
        @(negedge clk);
        checkOutput("rstmid stall c1", 32'(stall_s[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_write_s[0] = 1'b0;
        rdata_model[0] = '0;
        rdata_model[1] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkIdleOutputs(0, $sformatf("rstmid after c%0d", c));
            checkOutput($sformatf("rstmid err c%0d", c), 32'(err_s[0]), 32'd0);
        end
    endtask

    task automatic randomOps(input int u, input int n);
        logic [31:0] a;
        int          kind;
        for (int w = 0; w < 16; w++) begin
            applyStimulus(u, 1'b0, 1'b1, {$urandom_range(0, 3) << 10} | 32'(w * 4), $urandom);
        end
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 9);
            a    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
            if (kind < 4)       applyStimulus(u, 1'b0, 1'b1, a, $urandom);
            else if (kind < 8)  applyStimulus(u, 1'b1, 1'b0, a, $urandom);
            else if (kind == 8) applyStimulus(u, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom);
            else                applyStimulus(u, 1'b1, 1'b1, a, $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            mem_read_s[u]  = 1'b0;
            mem_write_s[u] = 1'b0;
            addr_s[u]      = '0;
            wdata_s[u]     = '0;
            rdata_model[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkIdleOutputs(u, "reset");
            checkOutput($sformatf("u%0d reset err", u), 32'(err_s[u]), 32'd0);
        end

        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        checkOutput("lw 0x10 value", rdata_model[0], 32'hDEADBEEF);
        holdCheck(0, 5);
        applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h1);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h11111111);
        resetMidStore(32'h30, 32'hA5A5A5A5);
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'h12345678);
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("alias lw 0x0 value", rdata_model[0], 32'h12345678);

        applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0);
        holdCheck(1, 5);

        randomOps(0, 40);
        randomOps(1, 25);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
